// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
// Contents: default sizing constants, arbiter state enum, ID width helper.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_BURST  = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Bits needed to index n requesters; never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - round-robin pointer; search starts at this index
//   found - at least one request is set
//   idx   - first set request at or after ptr, wrapping modulo NUM_REQ
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      enc;
  logic [SUM_W-1:0]     sum;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NUM_REQ'(req_dbl >> ptr);
    found   = |req_rot;
    enc     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = ID_W'(i);
    end
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant is held for a whole burst, released on LAST or after MAX_BURST beats.
// Ports:
//   ACLK, ARESET   - clock, asynchronous active-high reset
//   REQ_VALID/REQ_DATA/REQ_LAST/REQ_READY - per-requester beat handshake
//   FIFO_FULL      - FIFO full flag, stalls the granted requester
//   FIFO_WR_EN/FIFO_DATA_IN - FIFO write port (combinational, gated by state)
//   GRANT_ID       - index of the granted requester
//   BUSY           - high while a grant is locked
// Optional: define FIFO_ARB_ID_TAG_EN to prepend GRANT_ID to FIFO_DATA_IN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
  localparam int unsigned ID_W      = id_width(NUM_REQ),
`ifdef FIFO_ARB_ID_TAG_EN
  localparam int unsigned FW        = DATA_WIDTH + ID_W
`else
  localparam int unsigned FW        = DATA_WIDTH
`endif
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_WR_EN,
  output logic [FW-1:0]                 FIFO_DATA_IN,
  output logic [ID_W-1:0]               GRANT_ID,
  output logic                          BUSY
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic [DATA_WIDTH-1:0] payload;
  logic                  accept;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (REQ_VALID),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, pointer, grant and beat-count registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and write-port logic; the write path is only open while locked.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    REQ_READY    = '0;
    FIFO_WR_EN   = 1'b0;
    FIFO_DATA_IN = '0;
    accept       = 1'b0;
    payload      = REQ_DATA[grant_q*DATA_WIDTH +: DATA_WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        REQ_READY[grant_q] = ~FIFO_FULL;
        accept             = REQ_VALID[grant_q] & ~FIFO_FULL;
        FIFO_WR_EN         = accept;
`ifdef FIFO_ARB_ID_TAG_EN
        FIFO_DATA_IN       = {grant_q, payload};
`else
        FIFO_DATA_IN       = payload;
`endif
        if (accept) begin
          // Count tops out at MAX_BURST-1, so release always precedes wrap.
          if (REQ_LAST[grant_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d = ST_IDLE;
            ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign GRANT_ID = grant_q;
  assign BUSY     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=16).
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 16;
  localparam int unsigned IW = 2;
`ifdef FIFO_ARB_ID_TAG_EN
  localparam int unsigned FW = DW + IW;
`else
  localparam int unsigned FW = DW;
`endif

  logic             ACLK;
  logic             ARESET;
  logic [NR-1:0]    REQ_VALID;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]    REQ_LAST;
  logic [NR-1:0]    REQ_READY;
  logic             FIFO_FULL;
  logic             FIFO_WR_EN;
  logic [FW-1:0]    FIFO_DATA_IN;
  logic [IW-1:0]    GRANT_ID;
  logic             BUSY;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .REQ_VALID    (REQ_VALID),
    .REQ_DATA     (REQ_DATA),
    .REQ_LAST     (REQ_LAST),
    .REQ_READY    (REQ_READY),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR_EN   (FIFO_WR_EN),
    .FIFO_DATA_IN (FIFO_DATA_IN),
    .GRANT_ID     (GRANT_ID),
    .BUSY         (BUSY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    logic [FW-1:0] d;
    logic [IW-1:0] g;
    int            cyc;
  } wr_t;

  wr_t           log_q[$];
  logic [DW-1:0] rq_data [NR][$];
  bit            rq_last [NR][$];
  bit            hold    [NR];
  bit            full_req;
  logic [NR-1:0] acc_s;
  logic          wr_s;
  logic [FW-1:0] wd_s;
  logic [IW-1:0] wg_s;
  int            cyc_cnt;
  int            n_checks;
  int            n_errors;

  // Present each requester's queue head; FULL follows the requested level.
  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      REQ_VALID[i]          = (rq_data[i].size() > 0) && !hold[i];
      REQ_DATA[i*DW +: DW]  = (rq_data[i].size() > 0) ? rq_data[i][0] : '0;
      REQ_LAST[i]           = (rq_last[i].size() > 0) ? rq_last[i][0] : 1'b0;
    end
    FIFO_FULL = full_req;
  endtask

  // Mid-cycle snapshot of the handshake that the next rising edge will commit.
  always @(negedge ACLK) begin
    acc_s = REQ_VALID & REQ_READY;
    wr_s  = FIFO_WR_EN;
    wd_s  = FIFO_DATA_IN;
    wg_s  = GRANT_ID;
  end

  // Requester queues and FIFO model advance on the edge, then inputs are redriven.
  always @(posedge ACLK) begin
    if (!ARESET) begin
      wr_t e;
      cyc_cnt++;
      for (int i = 0; i < NR; i++) begin
        if (acc_s[i] && rq_data[i].size() > 0) begin
          void'(rq_data[i].pop_front());
          void'(rq_last[i].pop_front());
        end
      end
      if (wr_s) begin
        e.d = wd_s; e.g = wg_s; e.cyc = cyc_cnt;
        log_q.push_back(e);
      end
    end
    #1 drive_reqs();
  end

  task automatic push_beat(input int r, input logic [DW-1:0] d, input bit last);
    rq_data[r].push_back(d);
    rq_last[r].push_back(last);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
      hold[i] = 1'b0;
    end
    full_req = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (log_q.size() < n && k < 200) begin
      @(negedge ACLK);
      k++;
    end
    n_checks++;
    if (log_q.size() < n) begin
      n_errors++;
      $display("FAIL %s: writes seen %0d, required %0d", name, log_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    clear_reqs();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    n_checks += 5;
    if (REQ_READY !== '0)    begin n_errors++; $display("FAIL reset_ready: got %b, want 0", REQ_READY); end
    if (FIFO_WR_EN !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en: got %b, want 0", FIFO_WR_EN); end
    if (FIFO_DATA_IN !== '0) begin n_errors++; $display("FAIL reset_data: got %h, want 0", FIFO_DATA_IN); end
    if (GRANT_ID !== '0)     begin n_errors++; $display("FAIL reset_grant: got %0d, want 0", GRANT_ID); end
    if (BUSY !== 1'b0)       begin n_errors++; $display("FAIL reset_busy: got %b, want 0", BUSY); end
    ARESET = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    logic [IW-1:0] exp_g [3] = '{2'd3, 2'd0, 2'd1};
    @(negedge ACLK);
    push_beat(1, 8'h11, 1'b0);
    push_beat(1, 8'h22, 1'b0);
    push_beat(1, 8'h33, 1'b1);
    @(negedge ACLK);
    n_checks += 2;
    if (BUSY !== 1'b0)       begin n_errors++; $display("FAIL single_idle_busy: got %b, want 0", BUSY); end
    if (FIFO_WR_EN !== 1'b0) begin n_errors++; $display("FAIL single_idle_wr: got %b, want 0", FIFO_WR_EN); end
    @(negedge ACLK);
    n_checks += 3;
    if (GRANT_ID !== 2'd1)      begin n_errors++; $display("FAIL single_grant: got %0d, want 1", GRANT_ID); end
    if (BUSY !== 1'b1)          begin n_errors++; $display("FAIL single_busy: got %b, want 1", BUSY); end
    if (REQ_READY !== 4'b0010)  begin n_errors++; $display("FAIL single_ready: got %b, want 0010", REQ_READY); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge ACLK);
      n_checks += 2;
      if (FIFO_WR_EN !== 1'b1) begin n_errors++; $display("FAIL single_wr_beat%0d: got %b, want 1", k, FIFO_WR_EN); end
      if (FIFO_DATA_IN[DW-1:0] !== exp_d[k]) begin
        n_errors++; $display("FAIL single_data_beat%0d: got %h, want %h", k, FIFO_DATA_IN[DW-1:0], exp_d[k]);
      end
    end
    @(negedge ACLK);
    n_checks += 2;
    if (BUSY !== 1'b0)       begin n_errors++; $display("FAIL single_release_busy: got %b, want 0", BUSY); end
    if (FIFO_WR_EN !== 1'b0) begin n_errors++; $display("FAIL single_release_wr: got %b, want 0", FIFO_WR_EN); end
    // Pointer now 2: with requesters 0, 1 and 3 waiting, order is 3, 0, 1.
    push_beat(0, 8'hD0, 1'b1);
    push_beat(1, 8'hD1, 1'b1);
    push_beat(3, 8'hD3, 1'b1);
    wait_log(6, "single_ptr_writes");
    for (int k = 0; k < 3 && 3 + k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[3+k].g !== exp_g[k]) begin
        n_errors++; $display("FAIL single_ptr_order%0d: got %0d, want %0d", k, log_q[3+k].g, exp_g[k]);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    @(negedge ACLK);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) push_beat(i, DW'(8'hA0 + 16 * k + i), 1'b1);
    wait_log(8, "rr_writes");
    for (int j = 0; j < 8 && j < log_q.size(); j++) begin
      logic [DW-1:0] ed;
      ed = DW'(8'hA0 + 16 * (j / 4) + (j % 4));
      n_checks += 2;
      if (log_q[j].g !== IW'(j % 4)) begin
        n_errors++; $display("FAIL rr_order%0d: got %0d, want %0d", j, log_q[j].g, j % 4);
      end
      if (log_q[j].d[DW-1:0] !== ed) begin
        n_errors++; $display("FAIL rr_data%0d: got %h, want %h", j, log_q[j].d[DW-1:0], ed);
      end
      if (j > 0) begin
        n_checks++;
        if (log_q[j].cyc - log_q[j-1].cyc != 2) begin
          n_errors++; $display("FAIL rr_bubble%0d: got gap %0d, want 2", j, log_q[j].cyc - log_q[j-1].cyc);
        end
      end
    end
  endtask

  task automatic test_max_burst();
    do_reset();
    @(negedge ACLK);
    for (int k = 0; k < 20; k++) push_beat(0, DW'(8'h40 + k), 1'b0);
    push_beat(2, 8'hC0, 1'b1);
    wait_log(4, "cap_start");
    n_checks += 2;
    if (REQ_READY !== 4'b0001) begin n_errors++; $display("FAIL cap_ready_onehot: got %b, want 0001", REQ_READY); end
    if (GRANT_ID !== 2'd0)     begin n_errors++; $display("FAIL cap_grant: got %0d, want 0", GRANT_ID); end
    wait_log(21, "cap_writes");
    for (int j = 0; j < 21 && j < log_q.size(); j++) begin
      logic [DW-1:0] ed;
      logic [IW-1:0] eg;
      if (j < 16)       begin ed = DW'(8'h40 + j);     eg = 2'd0; end
      else if (j == 16) begin ed = 8'hC0;              eg = 2'd2; end
      else              begin ed = DW'(8'h40 + j - 1); eg = 2'd0; end
      n_checks += 2;
      if (log_q[j].g !== eg) begin
        n_errors++; $display("FAIL cap_grant%0d: got %0d, want %0d", j, log_q[j].g, eg);
      end
      if (log_q[j].d[DW-1:0] !== ed) begin
        n_errors++; $display("FAIL cap_data%0d: got %h, want %h", j, log_q[j].d[DW-1:0], ed);
      end
    end
    @(negedge ACLK);
    n_checks++;
    if (BUSY !== 1'b1) begin n_errors++; $display("FAIL cap_wait_locked: got %b, want 1", BUSY); end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    @(negedge ACLK);
    for (int k = 1; k <= 5; k++) push_beat(0, DW'(k), k == 5);
    wait_log(2, "full_start");
    full_req = 1'b1;
    @(negedge ACLK);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge ACLK);
      n_checks += 3;
      if (REQ_READY !== '0)    begin n_errors++; $display("FAIL full_ready%0d: got %b, want 0", k, REQ_READY); end
      if (FIFO_WR_EN !== 1'b0) begin n_errors++; $display("FAIL full_wr%0d: got %b, want 0", k, FIFO_WR_EN); end
      if (BUSY !== 1'b1)       begin n_errors++; $display("FAIL full_busy%0d: got %b, want 1", k, BUSY); end
    end
    full_req = 1'b0;
    @(negedge ACLK);
    n_checks += 2;
    if (FIFO_WR_EN !== 1'b1)            begin n_errors++; $display("FAIL full_resume_wr: got %b, want 1", FIFO_WR_EN); end
    if (FIFO_DATA_IN[DW-1:0] !== 8'h04) begin n_errors++; $display("FAIL full_resume_data: got %h, want 04", FIFO_DATA_IN[DW-1:0]); end
    wait_log(5, "full_writes");
    repeat (3) @(negedge ACLK);
    n_checks++;
    if (log_q.size() != 5) begin n_errors++; $display("FAIL full_count: got %0d, want 5", log_q.size()); end
    for (int j = 0; j < 5 && j < log_q.size(); j++) begin
      n_checks++;
      if (log_q[j].d[DW-1:0] !== DW'(j + 1)) begin
        n_errors++; $display("FAIL full_data%0d: got %h, want %h", j, log_q[j].d[DW-1:0], j + 1);
      end
    end
  endtask

  task automatic test_gap_and_reset();
    do_reset();
    @(negedge ACLK);
    push_beat(1, 8'hC1, 1'b1);
    wait_log(1, "gap_pre");
    push_beat(0, 8'hA1, 1'b0);
    push_beat(0, 8'hA2, 1'b0);
    push_beat(0, 8'hA3, 1'b1);
    wait_log(2, "gap_first");
    hold[0] = 1'b1;
    @(negedge ACLK);
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      n_checks += 3;
      if (BUSY !== 1'b1)       begin n_errors++; $display("FAIL gap_busy%0d: got %b, want 1", k, BUSY); end
      if (FIFO_WR_EN !== 1'b0) begin n_errors++; $display("FAIL gap_wr%0d: got %b, want 0", k, FIFO_WR_EN); end
      if (GRANT_ID !== 2'd0)   begin n_errors++; $display("FAIL gap_grant%0d: got %0d, want 0", k, GRANT_ID); end
    end
    n_checks++;
    if (log_q.size() != 3) begin n_errors++; $display("FAIL gap_count: got %0d, want 3", log_q.size()); end
    hold[0] = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (FIFO_WR_EN !== 1'b1) begin n_errors++; $display("FAIL gap_resume_wr: got %b, want 1", FIFO_WR_EN); end
    #2 ARESET = 1'b1;
    #1;
    n_checks += 4;
    if (BUSY !== 1'b0)       begin n_errors++; $display("FAIL areset_busy: got %b, want 0", BUSY); end
    if (FIFO_WR_EN !== 1'b0) begin n_errors++; $display("FAIL areset_wr: got %b, want 0", FIFO_WR_EN); end
    if (REQ_READY !== '0)    begin n_errors++; $display("FAIL areset_ready: got %b, want 0", REQ_READY); end
    if (GRANT_ID !== '0)     begin n_errors++; $display("FAIL areset_grant: got %0d, want 0", GRANT_ID); end
    clear_reqs();
    push_beat(0, 8'hB0, 1'b1);
    push_beat(3, 8'hB3, 1'b1);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    log_q.delete();
    wait_log(2, "areset_after");
    if (log_q.size() >= 2) begin
      n_checks += 2;
      if (log_q[0].g !== 2'd0) begin n_errors++; $display("FAIL areset_first_grant: got %0d, want 0", log_q[0].g); end
      if (log_q[1].g !== 2'd3) begin n_errors++; $display("FAIL areset_second_grant: got %0d, want 3", log_q[1].g); end
    end
  endtask

  task automatic test_tag();
    int k = 0;
    do_reset();
    @(negedge ACLK);
    push_beat(3, 8'hAB, 1'b1);
    while (FIFO_WR_EN !== 1'b1 && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    n_checks++;
`ifdef FIFO_ARB_ID_TAG_EN
    if (FIFO_DATA_IN !== 10'b11_1010_1011) begin
      n_errors++; $display("FAIL tag_data: got %b, want 1110101011", FIFO_DATA_IN);
    end
`else
    if (FIFO_DATA_IN !== 8'hAB) begin
      n_errors++; $display("FAIL untagged_data: got %h, want ab", FIFO_DATA_IN);
    end
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc_cnt   = 0;
    ARESET    = 1'b1;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    FIFO_FULL = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_fairness();
    test_max_burst();
    test_full_backpressure();
    test_gap_and_reset();
    test_tag();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
